// File: rtl/huc6280_pkg.sv
// huc6280_pkg
// Shared definitions for the HuC6280 timer block:
//   TMR_BASE / TMR_CTL / IRQ_ACK : physical I/O addresses on the 21-bit bus
//   TIQ                          : bit index of the timer request in the IRQ status byte
//   tmr_cnt_t                    : 7-bit timer count type
package huc6280_pkg;

  localparam logic [20:0] TMR_BASE = 21'h1FEC00;
  localparam logic [20:0] TMR_CTL  = 21'h1FEC01;
  localparam logic [20:0] IRQ_ACK  = 21'h1FF403;

  localparam int TIQ = 2;

  typedef logic [6:0] tmr_cnt_t;

endpackage

// File: rtl/huc6280_timer_prescaler.sv
// huc6280_prescaler
// Free-running divider that produces one tick every PRESCALE enabled cycles.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-low reset
//   en    in  count enable; the count holds while low
//   clr   in  synchronous clear back to 0 (wins over en)
//   tick  out high in the cycle where the count sits at PRESCALE-1 while enabled
module huc6280_prescaler #(
  parameter int PRESCALE = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/huc6280_timer.sv
// huc6280_timer
// HuC6280 on-chip timer as a responder on the CPU physical bus. A 7-bit
// down-counter decrements on every prescaler tick; on underflow it reloads
// and raises a level interrupt that the CPU clears by writing ACK_ADDR.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-low reset
//   AB_21    in  CPU physical address
//   DO       in  CPU write data
//   RE / WE  in  CPU read / write strobes
//   rd_data  out registered read data toward CPU DI
//   rd_valid out rd_data valid this cycle
//   tiq      out timer interrupt request (level, active-high)
module huc6280_timer #(
  parameter int          PRESCALE = 1024,
  parameter logic [20:0] TMR_BASE = huc6280_pkg::TMR_BASE,
  parameter logic [20:0] ACK_ADDR = huc6280_pkg::IRQ_ACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] AB_21,
  input  logic [7:0]  DO,
  input  logic        RE,
  input  logic        WE,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        tiq
);

  localparam logic [20:0] CTL_ADDR = TMR_BASE + 21'd1;

  huc6280_pkg::tmr_cnt_t r_counter;
  huc6280_pkg::tmr_cnt_t r_reload;
  logic                  r_enable;
  logic                  r_tiq;
  logic [7:0]            r_rd_data;
  logic                  r_rd_valid;

  logic                  w_hit_cnt;
  logic                  w_hit_ctl;
  logic                  w_hit_ack;
  logic                  w_wr_ctl;
  logic                  w_en_rise;
  logic                  w_tick;
  logic                  w_underflow;
  huc6280_pkg::tmr_cnt_t w_reload_next;

  assign w_hit_cnt = (AB_21 == TMR_BASE);
  assign w_hit_ctl = (AB_21 == CTL_ADDR);
  assign w_hit_ack = (AB_21 == ACK_ADDR);

  assign w_wr_ctl  = WE && w_hit_ctl;
  assign w_en_rise = w_wr_ctl && DO[0] && !r_enable;

  // Same-edge reload writes are visible to both the enable restart and an
  // underflow reload, so both use the post-write value.
  assign w_reload_next = (WE && w_hit_cnt) ? DO[6:0] : r_reload;

  // Clearing the prescaler on the enable edge makes the first decrement land
  // a full PRESCALE cycles after enabling.
  huc6280_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (r_enable),
    .clr   (w_en_rise),
    .tick  (w_tick)
  );

  assign w_underflow = w_tick && (r_counter == 7'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_counter  <= 7'd0;
      r_reload   <= 7'd0;
      r_enable   <= 1'b0;
      r_tiq      <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_reload <= w_reload_next;

      if (w_wr_ctl) r_enable <= DO[0];

      // w_tick needs r_enable=1 and w_en_rise needs r_enable=0, so these
      // never collide. A tick on the disabling edge is still applied.
      if (w_en_rise) begin
        r_counter <= w_reload_next;
      end else if (w_tick) begin
        if (r_counter == 7'd0) r_counter <= w_reload_next;
        else                   r_counter <= r_counter - 7'd1;
      end

      // Underflow wins over a same-edge acknowledge.
      if (w_underflow)            r_tiq <= 1'b1;
      else if (WE && w_hit_ack)   r_tiq <= 1'b0;

      // Reads sample the registers before this edge's updates.
      if (RE && w_hit_cnt) begin
        r_rd_data  <= {1'b0, r_counter};
        r_rd_valid <= 1'b1;
      end else if (RE && w_hit_ctl) begin
        r_rd_data  <= {7'b0, r_enable};
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign tiq      = r_tiq;

endmodule

// File: tb/tb_huc6280_timer.sv
module tb_huc6280_timer;
  import huc6280_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] AB_21;
  logic [7:0]  DO;
  logic        RE, WE;
  logic [7:0]  rd_data;
  logic        rd_valid, tiq;

  logic        b_reset;
  logic [20:0] b_AB_21;
  logic [7:0]  b_DO;
  logic        b_RE, b_WE;
  logic [7:0]  b_rd_data;
  logic        b_rd_valid, b_tiq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    string      nm;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  huc6280_timer #(.PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .AB_21(AB_21), .DO(DO), .RE(RE), .WE(WE),
    .rd_data(rd_data), .rd_valid(rd_valid), .tiq(tiq)
  );

  huc6280_timer #(.PRESCALE(1024)) dut_big (
    .clk(clk), .reset(b_reset), .AB_21(b_AB_21), .DO(b_DO), .RE(b_RE), .WE(b_WE),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .tiq(b_tiq)
  );

  // Scoreboard monitor: every rd_valid pulse pops one expected read.
  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rd_valid: rd_data=%02h with no read outstanding", rd_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rd_data !== e.d) begin
          bad++;
          $display("FAIL %s: rd_data=%02h expected=%02h", e.nm, rd_data, e.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b expected=%0b", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [20:0] a, input logic [7:0] d);
    AB_21 = a; DO = d; WE = 1'b1;
    @(posedge clk); #1;
    WE = 1'b0;
  endtask

  task automatic rd(input logic [20:0] a, input logic [7:0] e, input string nm);
    exp_t x;
    x.d = e; x.nm = nm;
    q.push_back(x);
    AB_21 = a; RE = 1'b1;
    @(posedge clk); #1;
    RE = 1'b0;
  endtask

  task automatic rw(input logic [20:0] a, input logic [7:0] d, input logic [7:0] e, input string nm);
    exp_t x;
    x.d = e; x.nm = nm;
    q.push_back(x);
    AB_21 = a; DO = d; RE = 1'b1; WE = 1'b1;
    @(posedge clk); #1;
    RE = 1'b0; WE = 1'b0;
  endtask

  logic [7:0] seq_exp [5];

  initial begin
    reset = 1'b0; AB_21 = '0; DO = '0; RE = 1'b0; WE = 1'b0;
    b_reset = 1'b0; b_AB_21 = '0; b_DO = '0; b_RE = 1'b0; b_WE = 1'b0;
    seq_exp[0] = 8'h03; seq_exp[1] = 8'h02; seq_exp[2] = 8'h01;
    seq_exp[3] = 8'h00; seq_exp[4] = 8'h03;

    cyc(3);
    chk("reset_tiq", tiq, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    reset = 1'b1;
    rd(TMR_BASE, 8'h00, "reset_counter");
    rd(TMR_CTL, 8'h00, "reset_enable");

    // Count sequence at reload 3; enable lands on edge E0.
    wr(TMR_BASE, 8'h03);
    wr(TMR_CTL, 8'h01);
    for (int i = 0; i < 4; i++) begin
      rd(TMR_BASE, seq_exp[i], "count_seq");
      if (i < 3) cyc(3);
    end
    cyc(2);
    chk("tiq_before_16", tiq, 1'b0);
    cyc(1);
    chk("tiq_at_16", tiq, 1'b1);
    rd(TMR_BASE, seq_exp[4], "count_reloaded");

    // Acknowledge, then acknowledge on the underflow edge (E32).
    wr(IRQ_ACK, 8'hA5);
    chk("ack_clears", tiq, 1'b0);
    cyc(13);
    chk("tiq_before_2nd", tiq, 1'b0);
    wr(IRQ_ACK, 8'h00);
    chk("ack_on_underflow_set_wins", tiq, 1'b1);
    wr(IRQ_ACK, 8'h00);
    chk("ack_second", tiq, 1'b0);

    // Disable at counter=2 with reload 5.
    wr(TMR_CTL, 8'h00);
    wr(TMR_BASE, 8'h05);
    wr(TMR_CTL, 8'h01);
    cyc(12);
    rw(TMR_CTL, 8'h00, 8'h01, "rw_pre_write_enable");
    rd(TMR_BASE, 8'h02, "frozen_start");
    cyc(48);
    rd(TMR_BASE, 8'h02, "frozen_after_50");
    chk("frozen_tiq", tiq, 1'b0);
    rd(TMR_CTL, 8'h00, "enable_off");
    wr(TMR_CTL, 8'h01);
    rd(TMR_BASE, 8'h05, "restart_at_reload");
    wr(TMR_CTL, 8'h01);
    cyc(2);
    rd(TMR_BASE, 8'h04, "no_restart_when_enabled");

    // Reload write on the underflow edge (H16) with reload 3.
    wr(TMR_CTL, 8'h00);
    wr(TMR_BASE, 8'h03);
    wr(TMR_CTL, 8'h01);
    cyc(15);
    chk("tiq_before_h16", tiq, 1'b0);
    wr(TMR_BASE, 8'h01);
    chk("tiq_at_h16", tiq, 1'b1);
    wr(IRQ_ACK, 8'h00);
    chk("ack_h17", tiq, 1'b0);
    rd(TMR_BASE, 8'h01, "underflow_loads_new_reload");
    cyc(5);
    chk("tiq_before_8cyc", tiq, 1'b0);
    cyc(1);
    chk("tiq_after_8cyc", tiq, 1'b1);
    rd(TMR_BASE, 8'h01, "reload1_after_underflow");

    // Reset while counter=4 and tiq=1.
    wr(TMR_BASE, 8'h05);
    cyc(10);
    rd(TMR_BASE, 8'h04, "counter_4_before_reset");
    chk("tiq_before_reset", tiq, 1'b1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("reset_mid_tiq", tiq, 1'b0);
    chk("reset_mid_rd_valid", rd_valid, 1'b0);
    rd(TMR_BASE, 8'h00, "reset_mid_counter");
    rd(TMR_CTL, 8'h00, "reset_mid_enable");
    cyc(20);
    rd(TMR_BASE, 8'h00, "reset_mid_still_idle");
    chk("reset_mid_tiq_later", tiq, 1'b0);

    // Read of the ack address is not decoded.
    AB_21 = IRQ_ACK; RE = 1'b1;
    cyc(1);
    RE = 1'b0;
    chk("ack_read_no_valid", rd_valid, 1'b0);

    // PRESCALE=1024, reload 0: underflow 1024 cycles after enable.
    b_reset = 1'b1;
    b_AB_21 = TMR_CTL; b_DO = 8'h01; b_WE = 1'b1;
    cyc(1);
    b_WE = 1'b0;
    cyc(1023);
    chk("big_tiq_before_1024", b_tiq, 1'b0);
    cyc(1);
    chk("big_tiq_at_1024", b_tiq, 1'b1);

    cyc(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_rd_valid: outstanding=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huc6280_timer.md
Name: huc6280_timer

Overview:
HuC6280 on-chip timer, implemented as a bus responder on the CPU's 21-bit physical bus: AB_21, DO, RE and WE, with read data returned toward the CPU DI.
- Holds a 7-bit down-counter clocked by a prescaler.
- Raises a level timer interrupt (TIQ) on each underflow.
- The interrupt is acknowledged by a CPU write to the IRQ-status address.
- Sits beside the memory model on the CPU bus; its interrupt output feeds the CPU interrupt logic.

Parameters:
- PRESCALE, 1024, clk cycles per counter decrement (minimum 2).
- TMR_BASE, 21'h1FEC00, physical address of the counter/reload register; TMR_BASE+1 is the control register.
- ACK_ADDR, 21'h1FF403, physical address whose write clears TIQ.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- AB_21  in  21  CPU physical address.
- DO  in  8  CPU write data.
- RE  in  1  CPU read strobe.
- WE  in  1  CPU write strobe.
- rd_data  out  8  read data toward CPU DI.
- rd_valid  out  1  rd_data is valid this cycle.
- tiq  out  1  timer interrupt request, level, active-high.

Behaviour:
- Reset (reset==0 at posedge): counter=7'h00, reload=7'h00, enable=0, prescaler count=0, tiq=0, rd_data=8'h00, rd_valid=0.
- Address decode, exact 21-bit compare:
  - hit_cnt = (AB_21==TMR_BASE)
  - hit_ctl = (AB_21==TMR_BASE+1)
  - hit_ack = (AB_21==ACK_ADDR)
- Writes take effect at the posedge where WE=1:
  - hit_cnt: reload <= DO[6:0]; the counter is not touched.
  - hit_ctl: enable <= DO[0]. On a 0->1 transition: counter <= reload (the post-write value if written the same cycle), prescaler <= 0.
  - hit_ack: tiq <= 0, unless an underflow occurs in the same cycle; set wins.
- Reads have one-cycle latency and are registered:
  - Posedge with RE=1 and hit_cnt: rd_data <= {1'b0, counter}, rd_valid <= 1.
  - Posedge with RE=1 and hit_ctl: rd_data <= {7'b0, enable}, rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds.
  - The value read is the counter before any same-cycle decrement.
  - A read of ACK_ADDR is not decoded; this block leaves rd_valid=0.
- Counting, only while enable=1:
  - The prescaler counts 0..PRESCALE-1 and wraps to 0. tick=1 in the cycle where prescaler==PRESCALE-1.
  - On tick with counter!=0: counter <= counter-1.
  - On tick with counter==0 (underflow): counter <= reload and tiq <= 1.
  - Period = (reload+1)*PRESCALE cycles. reload=0 gives an underflow every PRESCALE cycles.
- enable=0: prescaler and counter freeze (hold values); tiq holds.
- Simultaneous events:
  - Reload write on the same edge as an underflow: the underflow loads the new DO[6:0].
  - Control write 1 while already enabled: no restart.
  - Control write 0 on a tick edge: that tick is still applied, then the counter freezes.
- RE and WE both high: the write and the read both occur; the read returns the pre-write value.
- Reset asserted mid-count or with tiq=1: everything returns to reset values on that edge; no interrupt is pending afterwards.
- All arithmetic is 7-bit unsigned; no other wrap cases exist.

Decomposition:
- Package huc6280_pkg:
  - Localparams for the I/O physical addresses (TMR_BASE, TMR_CTL, IRQ_ACK).
  - IRQ bit indices (TIQ=2).
  - A typedef for the 7-bit timer count.
- One sub-module, huc6280_prescaler:
  - Inputs: clk, reset, en, clr.
  - Output: a one-cycle tick every PRESCALE enabled cycles.
  - Parameter: PRESCALE.

Test Plan (PRESCALE=4 unless noted):
- Reset, then read TMR_BASE -> rd_valid=1 one cycle later with rd_data=8'h00; tiq=0.
- Write 8'h03 to TMR_BASE, then write 8'h01 to TMR_BASE+1 -> tiq rises exactly 16 cycles after the enable edge; counter reads 3,2,1,0 in 4-cycle steps, then 3 again.
- With tiq=1, write any data to ACK_ADDR -> tiq=0 next cycle. An ack write on the underflow edge -> tiq stays 1.
- Enable running at reload 5: write 8'h00 to TMR_BASE+1 when counter=2 -> counter reads 2 for 50 cycles and tiq stays 0. Re-enable -> counter restarts at 5.
- Write reload 8'h01 on the underflow edge while reload=3 -> the next period is 8 cycles.
- Assert reset while counter=4 and tiq=1 -> next cycle tiq=0, counter=0, enable=0. PRESCALE=1024 with reload=0 -> tiq after 1024 cycles.
